// File: rtl/sonar_adc_serial_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sonar_adc_serial_ctrl
//  Purpose  : Runs one serial hydrophone ADC through a complete sample cycle.
//             It pulses convert-start, asserts chip select and generates the
//             serial clock. Each received bit is fed to an external
//             serial-in shift register. When the frame is complete, the
//             register's parallel word is latched and presented as a
//             one-cycle-valid sample.
//  Ports    : clk, reset          - system clock, async active-high reset
//             start               - sample request (acted on only when idle)
//             clear_overrun       - synchronous clear of the overrun flag
//             adc_sdo             - ADC serial data, MSB first
//             sr_q                - parallel word of the attached shift register
//             adc_convst/cs_n/sclk- ADC control pins
//             shift_d/shift_en    - serial bit and enable to the shift register
//             sample/sample_valid - captured word and its one-cycle strobe
//             busy/overrun        - status (overrun is sticky)
//  Revision : 1.0 - initial release
// ============================================================================
module sonar_adc_serial_ctrl #(
  parameter int WORD_BITS   = 16,
  parameter int CLK_DIV     = 2,
  parameter int CONV_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 clear_overrun,
  input  logic                 adc_sdo,
  input  logic [WORD_BITS-1:0] sr_q,
  output logic                 adc_convst,
  output logic                 adc_cs_n,
  output logic                 adc_sclk,
  output logic                 shift_d,
  output logic                 shift_en,
  output logic [WORD_BITS-1:0] sample,
  output logic                 sample_valid,
  output logic                 busy,
  output logic                 overrun
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CONV_W = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
  localparam int BIT_W  = $clog2(WORD_BITS + 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CONVERT = 3'd1,
    ST_SELECT  = 3'd2,
    ST_SHIFT   = 3'd3,
    ST_LATCH   = 3'd4
  } state_t;

  state_t               r_state,    w_state_nxt;
  logic [CONV_W-1:0]    r_conv_cnt, w_conv_nxt;
  logic [DIV_W-1:0]     r_div_cnt,  w_div_nxt;
  logic [BIT_W-1:0]     r_bit_cnt,  w_bit_nxt;
  logic                 r_convst,   w_convst_nxt;
  logic                 r_cs_n,     w_cs_n_nxt;
  logic                 r_sclk,     w_sclk_nxt;
  logic                 r_shift_d,  w_shift_d_nxt;
  logic                 r_shift_en, w_shift_en_nxt;
  logic [WORD_BITS-1:0] r_sample,   w_sample_nxt;
  logic                 r_valid,    w_valid_nxt;
  logic                 r_busy,     w_busy_nxt;
  logic                 r_overrun,  w_overrun_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_conv_cnt <= '0;
      r_div_cnt  <= '0;
      r_bit_cnt  <= '0;
      r_convst   <= 1'b0;
      r_cs_n     <= 1'b1;
      r_sclk     <= 1'b0;
      r_shift_d  <= 1'b0;
      r_shift_en <= 1'b0;
      r_sample   <= '0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_conv_cnt <= w_conv_nxt;
      r_div_cnt  <= w_div_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_convst   <= w_convst_nxt;
      r_cs_n     <= w_cs_n_nxt;
      r_sclk     <= w_sclk_nxt;
      r_shift_d  <= w_shift_d_nxt;
      r_shift_en <= w_shift_en_nxt;
      r_sample   <= w_sample_nxt;
      r_valid    <= w_valid_nxt;
      r_busy     <= w_busy_nxt;
      r_overrun  <= w_overrun_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_conv_nxt     = r_conv_cnt;
    w_div_nxt      = r_div_cnt;
    w_bit_nxt      = r_bit_cnt;
    w_convst_nxt   = r_convst;
    w_cs_n_nxt     = r_cs_n;
    w_sclk_nxt     = r_sclk;
    w_shift_d_nxt  = r_shift_d;
    w_shift_en_nxt = 1'b0;
    w_sample_nxt   = r_sample;
    w_valid_nxt    = 1'b0;

    // A start request outside IDLE (LATCH included) is only flagged. When a
    // set and a clear land in the same cycle, the set wins.
    w_overrun_nxt = r_overrun;
    if (start && (r_state != ST_IDLE)) begin
      w_overrun_nxt = 1'b1;
    end else if (clear_overrun) begin
      w_overrun_nxt = 1'b0;
    end

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt  = ST_CONVERT;
          w_convst_nxt = 1'b1;
          w_conv_nxt   = '0;
        end
      end
      ST_CONVERT: begin
        if (r_conv_cnt == CONV_W'(CONV_CYCLES - 1)) begin
          w_convst_nxt = 1'b0;
          w_cs_n_nxt   = 1'b0;
          w_state_nxt  = ST_SELECT;
        end else begin
          w_conv_nxt = r_conv_cnt + 1'b1;
        end
      end
      ST_SELECT: begin
        w_div_nxt   = '0;
        w_bit_nxt   = '0;
        w_sclk_nxt  = 1'b0;
        w_state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (r_div_cnt == DIV_W'(CLK_DIV - 1)) begin
          w_div_nxt = '0;
          if (!r_sclk) begin
            // Rising sclk edge: capture the bit the ADC has been holding.
            w_sclk_nxt     = 1'b1;
            w_shift_d_nxt  = adc_sdo;
            w_shift_en_nxt = 1'b1;
            w_bit_nxt      = r_bit_cnt + 1'b1;
          end else begin
            w_sclk_nxt = 1'b0;
            if (r_bit_cnt == BIT_W'(WORD_BITS)) begin
              w_state_nxt = ST_LATCH;
            end
          end
        end else begin
          w_div_nxt = r_div_cnt + 1'b1;
        end
      end
      ST_LATCH: begin
        // The final shift completed at least CLK_DIV-1 cycles ago, so sr_q
        // already holds the full word.
        w_sample_nxt = sr_q;
        w_valid_nxt  = 1'b1;
        w_cs_n_nxt   = 1'b1;
        w_state_nxt  = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  assign adc_convst   = r_convst;
  assign adc_cs_n     = r_cs_n;
  assign adc_sclk     = r_sclk;
  assign shift_d      = r_shift_d;
  assign shift_en     = r_shift_en;
  assign sample       = r_sample;
  assign sample_valid = r_valid;
  assign busy         = r_busy;
  assign overrun      = r_overrun;

endmodule
`default_nettype wire
